// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern-detect run controller:
// FSM state encodings and default pattern geometry.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int         DEF_PAT_W   = 5;
  localparam logic [4:0] DEF_PATTERN = 5'b10010;
  localparam int         DEF_CNT_W   = 8;
  localparam int         DEF_WIN_W   = 16;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Serial bit-stream handshake between the input front end (master)
// and the detection controller (slave).
interface seq_detect_ctrl_if;
  logic din;
  logic din_valid;
  logic din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/seq_detect_ctrl_pattern_matcher.sv
// Moore-style serial pattern matcher: shift history plus saturating fill
// count; overlapping matches are allowed because history survives a match.
module pattern_matcher
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic shift_en,
  input  logic din,
  output logic match,
  output logic hit
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift_s;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc_s;
  logic              match_q, match_d;

  // hit tells the controller whether shifting din now would complete the pattern
  always_comb begin
    hist_shift_s = {hist_q[PAT_W-2:0], din};
    if (fill_q == FILL_FULL) begin
      fill_inc_s = fill_q;
    end else begin
      fill_inc_s = fill_q + FILL_W'(1);
    end
    hit = (fill_inc_s == FILL_FULL) && (hist_shift_s == PATTERN);

    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d  = hist_shift_s;
      fill_d  = fill_inc_s;
      match_d = hit;
    end else begin
      hist_d = hist_q;
    end
  end

  // History, fill count and registered match pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: arms on start, counts detections against a threshold,
// bounds the run by an optional bit window, reports done/timeout until ack.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter int               WIN_W   = DEF_WIN_W
) (
  input  logic               clk,
  input  logic               reset_n,
  seq_detect_ctrl_if.slave   s_if,
  input  logic               start,
  input  logic               abort,
  input  logic               ack,
  input  logic [CNT_W-1:0]   threshold,
  input  logic [WIN_W-1:0]   window,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               done,
  output logic               timeout,
  output logic               busy,
  output logic [1:0]         state
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, thr_q, thr_d, cnt_inc_s;
  logic [WIN_W-1:0]   bits_q, bits_d, win_q, win_d, bits_inc_s;
  logic               din_ready_q, din_ready_d;
  logic               done_q, done_d, timeout_q, timeout_d, busy_q, busy_d;
  logic               accept_s, clr_s, shift_en_s, hit_s;

  pattern_matcher #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_matcher (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr_s),
    .shift_en (shift_en_s),
    .din      (s_if.din),
    .match    (match),
    .hit      (hit_s)
  );

  // Next-state, counters and latches; abort overrides everything else
  always_comb begin
    accept_s   = s_if.din_valid && din_ready_q;
    cnt_inc_s  = cnt_q + CNT_W'(1);
    bits_inc_s = bits_q + WIN_W'(1);
    state_d    = state_q;
    cnt_d      = cnt_q;
    bits_d     = bits_q;
    thr_d      = thr_q;
    win_d      = win_q;
    clr_s      = 1'b0;
    shift_en_s = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      clr_s   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ARMED;
            thr_d   = (threshold == CNT_W'(0)) ? CNT_W'(1) : threshold;
            win_d   = window;
            cnt_d   = '0;
            bits_d  = '0;
            clr_s   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (accept_s) begin
            shift_en_s = 1'b1;
            bits_d     = bits_inc_s;
            if (hit_s) begin
              cnt_d = cnt_inc_s;
            end else begin
              cnt_d = cnt_q;
            end
            // Threshold completion outranks window exhaustion on the same bit
            if (hit_s && (cnt_inc_s >= thr_q)) begin
              state_d = ST_DONE;
            end else if ((win_q != WIN_W'(0)) && (bits_inc_s == win_q)) begin
              state_d = ST_TIMEOUT;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          if (ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    din_ready_d = (state_d == ST_ARMED);
    busy_d      = (state_d == ST_ARMED);
    done_d      = (state_d == ST_DONE);
    timeout_d   = (state_d == ST_TIMEOUT);
  end

  // FSM state, counters, latches and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      thr_q       <= '0;
      win_q       <= '0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      thr_q       <= thr_d;
      win_q       <= win_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign s_if.din_ready = din_ready_q;
  assign match_count    = cnt_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign busy           = busy_q;
  assign state          = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: vector table of runs driven
// through a reference model and scoreboard, plus multi-cycle corner cases.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, ack;
  logic [7:0]  threshold;
  logic [15:0] window;
  logic        match, done, timeout, busy;
  logic [7:0]  match_count;
  logic [1:0]  state;

  seq_detect_ctrl_if dif ();

  seq_detect_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_if        (dif),
    .start       (start),
    .abort       (abort),
    .ack         (ack),
    .threshold   (threshold),
    .window      (window),
    .match       (match),
    .match_count (match_count),
    .done        (done),
    .timeout     (timeout),
    .busy        (busy),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic m;
    int   cnt;
    int   st;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          thr;
    int          win;
    int          n;
    logic [15:0] bits;
    int          e_cnt;
    int          e_st;
  } vec_t;

  // reference model
  logic [4:0] m_hist;
  int m_fill, m_cnt, m_bits, m_thr, m_win, m_st;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({dif.din_ready, match, match_count, done, timeout, busy, state}), 0);
  endtask

  task automatic do_start(input int thr, input int win);
    threshold = 8'(thr);
    window    = 16'(win);
    start     = 1'b1;
    step();
    start  = 1'b0;
    m_hist = 5'd0;
    m_fill = 0;
    m_cnt  = 0;
    m_bits = 0;
    m_thr  = (thr == 0) ? 1 : thr;
    m_win  = win;
    m_st   = 1;
    check("start_state", int'(state), 1);
    check("start_ready", int'(dif.din_ready), 1);
    check("start_count", int'(match_count), 0);
  endtask

  task automatic send_bit(input logic b);
    exp_t e, got;
    logic hit;
    if ($urandom_range(0, 3) == 0) begin
      dif.din_valid = 1'b0;
      dif.din       = ~b;
      step();
      check("stall_state", int'(state), m_st);
      check("stall_match", int'(match), 0);
    end
    dif.din       = b;
    dif.din_valid = 1'b1;
    e.m   = 1'b0;
    if (m_st == 1) begin
      m_hist = {m_hist[3:0], b};
      if (m_fill < 5) m_fill++;
      m_bits++;
      hit = (m_fill >= 5) && (m_hist == 5'b10010);
      if (hit) m_cnt++;
      e.m = hit;
      if (hit && m_cnt >= m_thr) m_st = 2;
      else if (m_win != 0 && m_bits == m_win) m_st = 3;
    end
    e.cnt = m_cnt;
    e.st  = m_st;
    sb.push_back(e);
    step();
    dif.din_valid = 1'b0;
    got = sb.pop_front();
    check("bit_match", int'(match), int'(got.m));
    check("bit_count", int'(match_count), got.cnt);
    check("bit_state", int'(state), got.st);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 0, 5,  16'b10010,       1, 2};
    vecs[1] = '{2, 0, 8,  16'b10010010,    2, 2};
    vecs[2] = '{1, 6, 6,  16'b111111,      0, 3};
    vecs[3] = '{1, 5, 5,  16'b10010,       1, 2};
    vecs[4] = '{3, 0, 11, 16'b10010010010, 3, 2};
    vecs[5] = '{0, 0, 5,  16'b10010,       1, 2};
    vecs[6] = '{2, 7, 7,  16'b1001001,     1, 3};
    vecs[7] = '{1, 0, 7,  16'b0110010,     1, 2};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
    threshold = 8'd0; window = 16'd0; dif.din = 1'b0; dif.din_valid = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    step();
    reset_n = 1'b1;
    dif.din_valid = 1'b1;
    step();
    check("idle_no_ready", int'(dif.din_ready), 0);
    check("idle_state", int'(state), 0);
    dif.din_valid = 1'b0;

    for (int v = 0; v < 8; v++) begin
      do_start(vecs[v].thr, vecs[v].win);
      for (int i = 0; i < vecs[v].n; i++) send_bit(vecs[v].bits[vecs[v].n - 1 - i]);
      check("end_state", int'(state), vecs[v].e_st);
      check("end_count", int'(match_count), vecs[v].e_cnt);
      check("end_done", int'(done), (vecs[v].e_st == 2) ? 1 : 0);
      check("end_timeout", int'(timeout), (vecs[v].e_st == 3) ? 1 : 0);
      check("end_ready", int'(dif.din_ready), 0);
      check("end_busy", int'(busy), 0);
      send_bit(1'b1);
      if (v == 0) begin
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored", int'(state), 2);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      m_st = 0;
      check("ack_state", int'(state), 0);
      check("ack_count_held", int'(match_count), vecs[v].e_cnt);
      check("ack_done_clr", int'(done | timeout), 0);
    end

    // abort mid-run must clear history so 100 + 10 does not form 10010
    do_start(1, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    m_st = 0;
    check("abort_state", int'(state), 0);
    check("abort_ready", int'(dif.din_ready), 0);
    do_start(1, 0);
    send_bit(1'b1); send_bit(1'b0);
    check("no_carry_count", int'(match_count), 0);

    // abort outranks ack and start
    abort = 1'b1; ack = 1'b1;
    step();
    abort = 1'b0; ack = 1'b0;
    check("abort_armed", int'(state), 0);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_over_start", int'(state), 0);

    // asynchronous reset mid-run with valid asserted
    do_start(2, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("pre_reset_count", int'(match_count), 1);
    dif.din = 1'b0;
    dif.din_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    check("post_reset_state", int'(state), 0);
    check("post_reset_ready", int'(dif.din_ready), 0);
    check("post_reset_flags", int'(done | timeout | match), 0);
    dif.din_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
